plic_irq_injector: RTL and testbench

- Programmable interrupt-stimulus stage that sits directly upstream of the PLIC top.
- Merges the device IRQ vector with scripted one-cycle IRQ pulses and produces the PLIC source vector.
- Replaces hardcoded cycle-compare test injection with a loadable schedule table: per-entry delay and IRQ id.
- Used for nesting, tail-chaining and NTS-full regression without RTL edits.

---
 rtl/plic_irq_injector_if.sv | 32 +++
 rtl/plic_irq_injector.sv | 122 ++++++++++++
 tb/tb_plic_irq_injector.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/plic_irq_injector_if.sv
// Bundles the schedule-load, control, IRQ vector and status signals of the injector.
interface plic_irq_injector_if #(
  parameter int IRQ_NUM    = 53,
  parameter int IRQ_ID_W   = 6,
  parameter int ENTRY_LOG2 = 4,
  parameter int DLY_W      = 32
);
  logic                  cfg_wr_en;
  logic [ENTRY_LOG2-1:0] cfg_wr_idx;
  logic [DLY_W-1:0]      cfg_wr_dly;
  logic [IRQ_ID_W-1:0]   cfg_wr_id;
  logic                  cfg_wr_last;
  logic                  arm;
  logic                  abort;
  logic [IRQ_NUM-1:0]    dev_irq_i;
  logic [IRQ_NUM-1:0]    irq_o;
  logic                  busy;
  logic                  done;
  logic [ENTRY_LOG2-1:0] cur_idx;

  modport master (
    output cfg_wr_en, cfg_wr_idx, cfg_wr_dly, cfg_wr_id, cfg_wr_last,
    output arm, abort, dev_irq_i,
    input  irq_o, busy, done, cur_idx
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_idx, cfg_wr_dly, cfg_wr_id, cfg_wr_last,
    input  arm, abort, dev_irq_i,
    output irq_o, busy, done, cur_idx
  );
endinterface

// File: rtl/plic_irq_injector.sv
// Scripted IRQ injector in front of the PLIC: walks a loadable table of
// {delay, id, last} entries, emitting a one-cycle pulse per entry, and ORs
// those pulses into the registered device IRQ vector. Bit 0 is forced low.
module plic_irq_injector #(
  parameter int IRQ_NUM    = 53,
  parameter int IRQ_ID_W   = 6,
  parameter int ENTRY_NUM  = 16,
  parameter int ENTRY_LOG2 = 4,
  parameter int DLY_W      = 32
) (
  input logic                clk,
  input logic                rst,
  plic_irq_injector_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [ENTRY_LOG2-1:0] LAST_IDX = ENTRY_LOG2'(ENTRY_NUM - 1);
  localparam logic [IRQ_NUM-1:0]    SRC_MASK = ~IRQ_NUM'(1);

  // Schedule table; deliberately not reset so it survives rst.
  logic [DLY_W-1:0]      r_dly  [ENTRY_NUM];
  logic [IRQ_ID_W-1:0]   r_id   [ENTRY_NUM];
  logic                  r_last [ENTRY_NUM];

  state_t                r_state;
  logic [DLY_W-1:0]      r_cnt;
  logic [ENTRY_LOG2-1:0] r_cur_idx;
  logic                  r_busy;
  logic                  r_done;
  logic [IRQ_NUM-1:0]    r_irq;

  logic                  w_wr_ok;
  logic                  w_fire;
  logic                  w_end;
  logic [ENTRY_LOG2-1:0] w_nxt_idx;
  logic [IRQ_NUM-1:0]    w_inj;

  // Writes are locked out while running or while an arm is being sampled,
  // so the run always starts from a stable table.
  assign w_wr_ok   = bus.cfg_wr_en && (r_state != S_RUN) && !bus.arm;
  // Abort suppresses the pulse of an entry firing on the same edge.
  assign w_fire    = (r_state == S_RUN) && (r_cnt == '0) && !bus.abort;
  // The physical last entry ends the run even without its last flag.
  assign w_end     = r_last[r_cur_idx] || (r_cur_idx == LAST_IDX);
  assign w_nxt_idx = r_cur_idx + ENTRY_LOG2'(1);

  // Table load port.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_dly[bus.cfg_wr_idx]  <= bus.cfg_wr_dly;
      r_id[bus.cfg_wr_idx]   <= bus.cfg_wr_id;
      r_last[bus.cfg_wr_idx] <= bus.cfg_wr_last;
    end
  end

  // One-hot decode of the firing entry's id; id 0 and ids past the vector
  // match no bit, so such entries only consume their time slot.
  always_comb begin
    w_inj = '0;
    for (int b = 1; b < IRQ_NUM; b++)
      w_inj[b] = w_fire && (r_id[r_cur_idx] == IRQ_ID_W'(b));
  end

  // Schedule sequencer with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cur_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (bus.abort) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cur_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.arm) begin
            r_state   <= S_RUN;
            r_cur_idx <= '0;
            r_cnt     <= r_dly[0];
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - DLY_W'(1);
          end else if (w_end) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cur_idx <= w_nxt_idx;
            r_cnt     <= r_dly[w_nxt_idx];
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Registered merge of device levels and injected pulses; bit 0 held low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= '0;
    else     r_irq <= (bus.dev_irq_i | w_inj) & SRC_MASK;
  end

  assign bus.irq_o   = r_irq;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.cur_idx = r_cur_idx;

endmodule

// File: tb/tb_plic_irq_injector.sv
// Bench for plic_irq_injector: directed scenarios plus random traffic, all
// checked every cycle against a schedule-level model (absolute pulse times).
module tb_plic_irq_injector;
  localparam int N  = 53;
  localparam int IW = 6;
  localparam int EN = 16;
  localparam int EL = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  plic_irq_injector_if #(.IRQ_NUM(N), .IRQ_ID_W(IW), .ENTRY_LOG2(EL), .DLY_W(DW)) bus ();

  plic_irq_injector #(.IRQ_NUM(N), .IRQ_ID_W(IW), .ENTRY_NUM(EN), .ENTRY_LOG2(EL), .DLY_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Table mirror plus the schedule of the current run as absolute edge numbers.
  int unsigned m_dly  [EN];
  int          m_id   [EN];
  bit          m_last [EN];
  bit          s_valid = 1'b0;
  longint      s_fire [EN];
  int          s_id   [EN];
  int          s_n = 0;
  longint      cyc = 0;

  function automatic bit m_busy(input longint e);
    if (!s_valid) return 1'b0;
    return e < s_fire[s_n-1];
  endfunction

  function automatic bit m_done(input longint e);
    if (!s_valid) return 1'b0;
    return e >= s_fire[s_n-1];
  endfunction

  function automatic int m_idx(input longint e);
    int c;
    c = 0;
    if (!s_valid) return 0;
    for (int k = 0; k < s_n; k++) if (s_fire[k] <= e) c++;
    return (c > s_n - 1) ? s_n - 1 : c;
  endfunction

  // Model update and output compare, once per clock edge.
  always @(posedge clk) begin : cmp
    logic [N-1:0] e_irq;
    bit           pb;
    longint       t;
    cyc++;
    e_irq = '0;
    if (rst) begin
      s_valid = 1'b0;
    end else begin
      pb = m_busy(cyc - 1);
      if (bus.cfg_wr_en && !pb && !bus.arm) begin
        m_dly[bus.cfg_wr_idx]  = bus.cfg_wr_dly;
        m_id[bus.cfg_wr_idx]   = int'(bus.cfg_wr_id);
        m_last[bus.cfg_wr_idx] = bus.cfg_wr_last;
      end
      if (bus.abort) begin
        s_valid = 1'b0;
      end else if (bus.arm && !pb) begin
        t = cyc;
        s_n = EN;
        for (int k = 0; k < EN; k++) begin
          t = t + longint'(m_dly[k]) + 1;
          s_fire[k] = t;
          s_id[k]   = m_id[k];
          if (m_last[k]) begin
            s_n = k + 1;
            break;
          end
        end
        s_valid = 1'b1;
      end
      e_irq = bus.dev_irq_i;
      if (s_valid)
        for (int k = 0; k < s_n; k++)
          if (s_fire[k] == cyc && s_id[k] >= 1 && s_id[k] < N) e_irq[s_id[k]] = 1'b1;
      e_irq[0] = 1'b0;
    end
    #1;
    chk("irq_o",   64'(bus.irq_o),   64'(e_irq));
    chk("busy",    64'(bus.busy),    64'(rst ? 1'b0 : m_busy(cyc)));
    chk("done",    64'(bus.done),    64'(rst ? 1'b0 : m_done(cyc)));
    chk("cur_idx", 64'(bus.cur_idx), rst ? 64'd0 : 64'(m_idx(cyc)));
  end

  // ---------------- driver ----------------
  task automatic cyc_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input int idx, input int dly, input int id, input bit last);
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_idx  = EL'(idx);
    bus.cfg_wr_dly  = DW'(dly);
    bus.cfg_wr_id   = IW'(id);
    bus.cfg_wr_last = last;
    cyc_n(1);
    bus.cfg_wr_en = 1'b0;
  endtask

  // Leaves the caller 2 time units after the arm edge E0.
  task automatic arm_pulse();
    bus.arm = 1'b1;
    cyc_n(1);
    bus.arm = 1'b0;
  endtask

  task automatic scen2_check(input string tag);
    cyc_n(3);
    chk({tag, "_e3_irq"}, 64'(bus.irq_o), 64'h0);
    cyc_n(1);
    chk({tag, "_e4_irq"}, 64'(bus.irq_o), 64'h4000);
    chk({tag, "_e4_idx"}, 64'(bus.cur_idx), 64'd1);
    cyc_n(1);
    chk({tag, "_e5_irq"}, 64'(bus.irq_o), 64'h2000);
    chk({tag, "_e5_idx"}, 64'(bus.cur_idx), 64'd2);
    cyc_n(3);
    chk({tag, "_e8_irq"}, 64'(bus.irq_o), 64'h1000);
    chk({tag, "_e8_done"}, 64'(bus.done), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_wr_en = 1'b0; bus.cfg_wr_idx = '0; bus.cfg_wr_dly = '0;
    bus.cfg_wr_id = '0;   bus.cfg_wr_last = 1'b0;
    bus.arm = 1'b0; bus.abort = 1'b0; bus.dev_irq_i = '0;

    cyc_n(3);
    chk("reset_irq",  64'(bus.irq_o), 64'h0);
    chk("reset_busy", 64'(bus.busy),  64'h0);
    rst = 1'b0;
    cyc_n(1);

    // 1: single entry, delay 5 -> pulse after E6
    wr(0, 5, 14, 1);
    arm_pulse();
    cyc_n(5);
    chk("t1_e5_irq", 64'(bus.irq_o), 64'h0);
    cyc_n(1);
    chk("t1_e6_irq",  64'(bus.irq_o), 64'h4000);
    chk("t1_e6_done", 64'(bus.done),  64'd1);
    chk("t1_e6_busy", 64'(bus.busy),  64'd0);
    cyc_n(1);
    chk("t1_e7_irq", 64'(bus.irq_o), 64'h0);

    // 2: three entries, back-to-back middle pulse
    wr(0, 3, 14, 0); wr(1, 0, 13, 0); wr(2, 2, 12, 1);
    arm_pulse();
    scen2_check("t2");

    // 3: device level on bit 5 overlapping injection; id 0 slot
    bus.dev_irq_i = N'(64'h20);
    wr(0, 2, 5, 0); wr(1, 3, 0, 0); wr(2, 1, 7, 1);
    arm_pulse();
    cyc_n(3);
    chk("t3_e3_irq", 64'(bus.irq_o), 64'h20);
    cyc_n(6);
    chk("t3_e9_irq", 64'(bus.irq_o), 64'hA0);
    bus.dev_irq_i = '0;
    cyc_n(2);

    // 4: full table without last flags ends at entry 15
    for (int k = 0; k < EN; k++) wr(k, 1, k + 20, 0);
    arm_pulse();
    cyc_n(32);
    chk("t4_e32_irq",  64'(bus.irq_o),   64'h1 << 35);
    chk("t4_e32_idx",  64'(bus.cur_idx), 64'd15);
    chk("t4_e32_done", 64'(bus.done),    64'd1);
    cyc_n(4);
    chk("t4_nowrap_irq", 64'(bus.irq_o),   64'h0);
    chk("t4_nowrap_idx", 64'(bus.cur_idx), 64'd15);

    // 5: abort together with fire and arm; write during RUN dropped
    wr(0, 3, 20, 1);
    arm_pulse();
    cyc_n(3);
    bus.abort = 1'b1; bus.arm = 1'b1;
    cyc_n(1);
    bus.abort = 1'b0; bus.arm = 1'b0;
    chk("t5_abort_irq",  64'(bus.irq_o),   64'h0);
    chk("t5_abort_busy", 64'(bus.busy),    64'd0);
    chk("t5_abort_done", 64'(bus.done),    64'd0);
    chk("t5_abort_idx",  64'(bus.cur_idx), 64'd0);
    arm_pulse();
    wr(0, 3, 30, 1);
    cyc_n(5);
    arm_pulse();
    cyc_n(4);
    chk("t5_rearm_irq", 64'(bus.irq_o), 64'h100000);

    // 6: reset mid-run, table retained across it
    wr(1, 0, 13, 0); wr(2, 2, 12, 1); wr(0, 200, 14, 0);
    bus.dev_irq_i = N'(64'h1F0_0000_00F0);
    arm_pulse();
    cyc_n(100);
    rst = 1'b1;
    #1;
    chk("t6_rst_irq",  64'(bus.irq_o), 64'h0);
    chk("t6_rst_busy", 64'(bus.busy),  64'd0);
    bus.dev_irq_i = '0;
    cyc_n(2);
    rst = 1'b0;
    cyc_n(1);
    wr(0, 3, 14, 0);
    arm_pulse();
    scen2_check("t6");

    // random traffic against the model
    for (int k = 0; k < EN; k++) wr(k, $urandom_range(0, 4), $urandom_range(0, 63), ($urandom_range(0, 3) == 0));
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) bus.dev_irq_i = N'({$urandom, $urandom});
      bus.arm         = ($urandom_range(0, 19) == 0);
      bus.abort       = ($urandom_range(0, 59) == 0);
      bus.cfg_wr_en   = ($urandom_range(0, 7) == 0);
      bus.cfg_wr_idx  = EL'($urandom_range(0, EN - 1));
      bus.cfg_wr_dly  = DW'($urandom_range(0, 4));
      bus.cfg_wr_id   = IW'($urandom_range(0, 63));
      bus.cfg_wr_last = ($urandom_range(0, 3) == 0);
      cyc_n(1);
    end
    bus.arm = 1'b0; bus.abort = 1'b0; bus.cfg_wr_en = 1'b0; bus.dev_irq_i = '0;
    cyc_n(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
